// File: rtl/keynsham_sdram_arbiter.sv
// rtl/keynsham_sdram_arbiter.sv - N-master SDRAM front end with fixed/round-robin arbitration,
// per-transaction timeout and a master-0 status/control register.
module keynsham_sdram_arbiter #(
  parameter int          NUM_MASTERS      = 2,
  parameter int          PRIORITY_MODE    = 0,
  parameter int          TIMEOUT_CYCLES   = 1024,
  parameter logic [31:0] bus_address      = 32'h0,
  parameter logic [31:0] bus_size         = 32'h0,
  parameter logic [31:0] ctrl_bus_address = 32'h0,
  parameter logic [31:0] ctrl_bus_size    = 32'h0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MASTERS-1:0]      m_access,
  input  logic [30*NUM_MASTERS-1:0]   m_addr,
  input  logic [NUM_MASTERS-1:0]      m_wr_en,
  input  logic [32*NUM_MASTERS-1:0]   m_wr_val,
  input  logic [4*NUM_MASTERS-1:0]    m_bytesel,
  output logic [NUM_MASTERS-1:0]      m_cs,
  output logic [NUM_MASTERS-1:0]      m_ack,
  output logic [NUM_MASTERS-1:0]      m_error,
  output logic [32*NUM_MASTERS-1:0]   m_data,
  output logic                        ctrl_cs,
  output logic                        c_cs,
  output logic [29:0]                 c_addr,
  output logic                        c_wr_en,
  output logic [3:0]                  c_bytesel,
  output logic [31:0]                 c_wdata,
  input  logic [31:0]                 c_rdata,
  input  logic                        c_compl,
  input  logic                        c_config_done
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t           state;
  logic [2:0]       g;
  logic [2:0]       rr_ptr;
  logic [31:0]      timer;
  logic [15:0]      timeout_count;
  logic             ctrl_ack;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] g_onehot;
  logic [7:0]       req8;
  logic [2:0]       next_g;
  logic             any_req;
  logic             ctrl_hit;
  logic [3:0]       idx;
  logic [29:0]      addr_a  [8];
  logic [31:0]      wval_a  [8];
  logic [3:0]       bsel_a  [8];
  logic [7:0]       wren8;

  // Windows are byte ranges; the buses carry word addresses.
  function automatic logic in_window(input logic [29:0] a, input logic [31:0] base,
                                     input logic [31:0] size);
    logic [31:0] byte_addr;
    byte_addr = {a, 2'b00};
    return (byte_addr >= base) && ((byte_addr - base) < size);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++)
      m_cs[i] = in_window(m_addr[30*i +: 30], bus_address, bus_size);
    ctrl_cs  = in_window(m_addr[29:0], ctrl_bus_address, ctrl_bus_size);
    ctrl_hit = m_access[0] & ctrl_cs;
    req      = m_access & m_cs;
    req[0]   = req[0] & ~ctrl_cs;
    req8     = '0;
    req8[NUM_MASTERS-1:0] = req;
  end

  always_comb begin
    next_g  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = ((PRIORITY_MODE == 1) ? {1'b0, rr_ptr} : 4'd0) + 4'(k);
      if (idx >= 4'(NUM_MASTERS)) idx = idx - 4'(NUM_MASTERS);
      if (!any_req && req8[idx[2:0]]) begin
        any_req = 1'b1;
        next_g  = idx[2:0];
      end
    end
  end

  always_comb begin
    wren8 = '0;
    for (int i = 0; i < 8; i++) begin
      addr_a[i] = '0;
      wval_a[i] = '0;
      bsel_a[i] = '0;
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      addr_a[i] = m_addr[30*i +: 30];
      wval_a[i] = m_wr_val[32*i +: 32];
      bsel_a[i] = m_bytesel[4*i +: 4];
      wren8[i]  = m_wr_en[i];
    end
    for (int i = 0; i < NUM_MASTERS; i++)
      g_onehot[i] = (g == 3'(i));
  end

  always_comb begin
    c_cs      = (state == BUSY);
    c_addr    = c_cs ? addr_a[g] : '0;
    c_wr_en   = c_cs ? wren8[g]  : 1'b0;
    c_bytesel = c_cs ? bsel_a[g] : '0;
    c_wdata   = c_cs ? wval_a[g] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      g             <= '0;
      rr_ptr        <= '0;
      timer         <= '0;
      timeout_count <= '0;
      ctrl_ack      <= 1'b0;
      m_ack         <= '0;
      m_error       <= '0;
      m_data        <= '0;
    end else begin
      m_ack    <= '0;
      m_error  <= '0;
      m_data   <= '0;
      ctrl_ack <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          g     <= next_g;
          timer <= 32'(TIMEOUT_CYCLES);
          state <= BUSY;
        end
        BUSY: if (c_compl) begin
          for (int i = 0; i < NUM_MASTERS; i++)
            if (g_onehot[i]) begin
              m_ack[i]           <= 1'b1;
              m_data[32*i +: 32] <= c_rdata;
            end
          rr_ptr <= (g == 3'(NUM_MASTERS-1)) ? 3'd0 : g + 3'd1;
          state  <= IDLE;
        end else if (TIMEOUT_CYCLES != 0 && timer == 32'd1) begin
          for (int i = 0; i < NUM_MASTERS; i++)
            if (g_onehot[i]) begin
              m_ack[i]   <= 1'b1;
              m_error[i] <= 1'b1;
            end
          if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
          state <= DRAIN;
        end else begin
          timer <= timer - 32'd1;
        end
        DRAIN: if (c_compl) state <= IDLE;
        default: state <= IDLE;
      endcase
      // Placed after the FSM so a control write's clear overrides a same-cycle increment.
      if (ctrl_hit && !ctrl_ack) begin
        ctrl_ack      <= 1'b1;
        m_ack[0]      <= 1'b1;
        m_data[31:0]  <= {15'b0, timeout_count, c_config_done};
        if (m_wr_en[0]) timeout_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_keynsham_sdram_arbiter.sv
// tb/tb_keynsham_sdram_arbiter.sv - directed bench: fixed N=2 instance and round-robin N=4 instance.
module tb_keynsham_sdram_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic config_done;
  always #5 clk = ~clk;

  logic [1:0]   m_access_a, m_wr_en_a, m_cs_a, m_ack_a, m_error_a;
  logic [59:0]  m_addr_a;
  logic [63:0]  m_wr_val_a, m_data_a;
  logic [7:0]   m_bytesel_a;
  logic         ctrl_cs_a, c_cs_a, c_wr_en_a, c_compl_a;
  logic [29:0]  c_addr_a;
  logic [3:0]   c_bytesel_a;
  logic [31:0]  c_wdata_a, c_rdata_a;

  logic [3:0]   m_access_b, m_wr_en_b, m_cs_b, m_ack_b, m_error_b;
  logic [119:0] m_addr_b;
  logic [127:0] m_wr_val_b, m_data_b;
  logic [15:0]  m_bytesel_b;
  logic         ctrl_cs_b, c_cs_b, c_wr_en_b, c_compl_b;
  logic [29:0]  c_addr_b;
  logic [3:0]   c_bytesel_b;
  logic [31:0]  c_wdata_b, c_rdata_b;

  keynsham_sdram_arbiter #(.NUM_MASTERS(2), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(16),
    .bus_address(32'h0), .bus_size(32'h0001_0000),
    .ctrl_bus_address(32'h0010_0000), .ctrl_bus_size(32'h10)) u_fix (
    .clk(clk), .rst(rst), .m_access(m_access_a), .m_addr(m_addr_a), .m_wr_en(m_wr_en_a),
    .m_wr_val(m_wr_val_a), .m_bytesel(m_bytesel_a), .m_cs(m_cs_a), .m_ack(m_ack_a),
    .m_error(m_error_a), .m_data(m_data_a), .ctrl_cs(ctrl_cs_a), .c_cs(c_cs_a),
    .c_addr(c_addr_a), .c_wr_en(c_wr_en_a), .c_bytesel(c_bytesel_a), .c_wdata(c_wdata_a),
    .c_rdata(c_rdata_a), .c_compl(c_compl_a), .c_config_done(config_done));

  keynsham_sdram_arbiter #(.NUM_MASTERS(4), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(1024),
    .bus_address(32'h0), .bus_size(32'h0001_0000),
    .ctrl_bus_address(32'h0010_0000), .ctrl_bus_size(32'h10)) u_rr (
    .clk(clk), .rst(rst), .m_access(m_access_b), .m_addr(m_addr_b), .m_wr_en(m_wr_en_b),
    .m_wr_val(m_wr_val_b), .m_bytesel(m_bytesel_b), .m_cs(m_cs_b), .m_ack(m_ack_b),
    .m_error(m_error_b), .m_data(m_data_b), .ctrl_cs(ctrl_cs_b), .c_cs(c_cs_b),
    .c_addr(c_addr_b), .c_wr_en(c_wr_en_b), .c_bytesel(c_bytesel_b), .c_wdata(c_wdata_b),
    .c_rdata(c_rdata_b), .c_compl(c_compl_b), .c_config_done(config_done));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Controller model: completes two cycles after c_cs rises; unwritten words read as a pattern.
  function automatic logic [31:0] pattern(input logic [29:0] a);
    return {2'b00, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] bs);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (bs[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  logic [31:0] mem_a [logic [29:0]];
  logic [31:0] mem_b [logic [29:0]];
  int cnt_a = 0, cnt_b = 0;
  logic hold_a = 1'b0, man_a = 1'b0, auto_a = 1'b0, auto_b = 1'b0;
  assign c_compl_a = auto_a | man_a;
  assign c_compl_b = auto_b;

  always @(negedge clk) begin
    auto_a = 1'b0;
    if (!c_cs_a) cnt_a = 0;
    else begin
      cnt_a++;
      if (cnt_a == 2 && !hold_a) begin
        if (c_wr_en_a) begin
          mem_a[c_addr_a] = merge(mem_a.exists(c_addr_a) ? mem_a[c_addr_a] : 32'h0,
                                  c_wdata_a, c_bytesel_a);
          c_rdata_a = 32'h0;
        end else c_rdata_a = mem_a.exists(c_addr_a) ? mem_a[c_addr_a] : pattern(c_addr_a);
        auto_a = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    auto_b = 1'b0;
    if (!c_cs_b) cnt_b = 0;
    else begin
      cnt_b++;
      if (cnt_b == 2) begin
        if (c_wr_en_b) begin
          mem_b[c_addr_b] = merge(mem_b.exists(c_addr_b) ? mem_b[c_addr_b] : 32'h0,
                                  c_wdata_b, c_bytesel_b);
          c_rdata_b = 32'h0;
        end else c_rdata_b = mem_b.exists(c_addr_b) ? mem_b[c_addr_b] : pattern(c_addr_b);
        auto_b = 1'b1;
      end
    end
  end

  logic multi_ack = 1'b0, data_leak = 1'b0;
  always @(negedge clk) begin
    if ($countones(m_ack_a) > 1 || $countones(m_ack_b) > 1) multi_ack = 1'b1;
    if ((m_ack_a == 2'b00 && m_data_a != 64'h0) || (m_ack_b == 4'h0 && m_data_b != 128'h0) ||
        (m_error_b != 4'h0) || ctrl_cs_b)
      data_leak = 1'b1;
  end

  task automatic acc_a(input int m, input logic [29:0] addr, input logic wr,
                       input logic [31:0] wv, input logic [3:0] bs,
                       output logic [31:0] rd, output logic err, output int lat,
                       output int glat, output logic [31:0] cap_wd, output logic [3:0] cap_bs);
    int first;
    first = -1; lat = 0; rd = '0; err = 1'b0; cap_wd = '0; cap_bs = '0;
    m_addr_a[30*m +: 30]   = addr;
    m_wr_en_a[m]           = wr;
    m_wr_val_a[32*m +: 32] = wv;
    m_bytesel_a[4*m +: 4]  = bs;
    m_access_a[m]          = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (c_cs_a && first < 0) begin
        first = n; cap_wd = c_wdata_a; cap_bs = c_bytesel_a;
      end
      if (m_ack_a[m]) begin
        lat = n; rd = m_data_a[32*m +: 32]; err = m_error_a[m];
        break;
      end
    end
    m_access_a[m] = 1'b0;
    m_wr_en_a[m]  = 1'b0;
    if (lat == 0) check("ack_wait_expired", 64'd0, 64'd1);
    glat = (first < 0) ? -1 : lat - first;
  endtask

  logic [31:0] rd, cwd;
  logic [3:0]  cbs;
  logic        err;
  int          lat, glat;
  int          order[$];
  logic [31:0] datas[$];
  int          seen;

  initial begin
    rst = 1'b1; config_done = 1'b1;
    m_access_a = '0; m_wr_en_a = '0; m_addr_a = '0; m_wr_val_a = '0; m_bytesel_a = '0;
    m_access_b = '0; m_wr_en_b = '0; m_addr_b = '0; m_wr_val_b = '0; m_bytesel_b = '0;
    c_rdata_a = '0; c_rdata_b = '0;
    repeat (3) @(negedge clk);
    check("rst_ack_a",  64'(m_ack_a),  64'h0);
    check("rst_data_a", 64'(m_data_a), 64'h0);
    check("rst_ccs_a",  64'(c_cs_a),   64'h0);
    check("rst_ccs_b",  64'(c_cs_b),   64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Fixed priority, simultaneous reads.
    m_addr_a = {30'h20, 30'h10}; m_bytesel_a = 8'hFF; m_access_a = 2'b11;
    #1 check("fix_cs", 64'(m_cs_a), 64'h3);
    for (int n = 0; n < 40 && order.size() < 2; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (m_ack_a[i]) begin
        order.push_back(i); datas.push_back(m_data_a[32*i +: 32]); m_access_a[i] = 1'b0;
      end
    end
    check("fix_count", 64'(order.size()), 64'd2);
    if (order.size() == 2) begin
      check("fix_first",  64'(order[0]), 64'd0);
      check("fix_second", 64'(order[1]), 64'd1);
      check("fix_data0",  64'(datas[0]), 64'h5A5A_0010);
      check("fix_data1",  64'(datas[1]), 64'h5A5A_0020);
    end

    // Round-robin, four held requests.
    order.delete(); datas.delete();
    m_addr_b = {30'h103, 30'h102, 30'h101, 30'h100}; m_bytesel_b = 16'hFFFF; m_access_b = 4'hF;
    #1 check("rr_cs", 64'(m_cs_b), 64'hF);
    for (int n = 0; n < 100 && order.size() < 5; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (m_ack_b[i]) begin
        order.push_back(i); datas.push_back(m_data_b[32*i +: 32]);
      end
      if (order.size() >= 5) m_access_b = 4'h0;
    end
    m_access_b = 4'h0;
    check("rr_count", 64'(order.size()), 64'd5);
    if (order.size() == 5) begin
      for (int k = 0; k < 5; k++) check($sformatf("rr_grant%0d", k), 64'(order[k]), 64'(k % 4));
      check("rr_data2", 64'(datas[2]), 64'h5A5A_0102);
    end

    // Partial write then readback.
    acc_a(1, 30'h30, 1'b1, 32'hDEAD_BEEF, 4'b0011, rd, err, lat, glat, cwd, cbs);
    check("wr_wdata", 64'(cwd), 64'hDEAD_BEEF);
    check("wr_bsel",  64'(cbs), 64'h3);
    check("wr_err",   64'(err), 64'h0);
    acc_a(1, 30'h30, 1'b0, 32'h0, 4'hF, rd, err, lat, glat, cwd, cbs);
    check("rb_data", 64'(rd), 64'h0000_BEEF);
    check("rb_lat",  64'(lat), 64'd3);

    // Timeout with a withheld completion, then a late completion.
    hold_a = 1'b1;
    acc_a(0, 30'h40, 1'b0, 32'h0, 4'hF, rd, err, lat, glat, cwd, cbs);
    check("to_err",   64'(err), 64'h1);
    check("to_data",  64'(rd), 64'h0);
    check("to_cycle", 64'(glat), 64'd16);
    check("to_drain_ccs", 64'(c_cs_a), 64'h0);
    man_a = 1'b1;
    @(negedge clk);
    man_a = 1'b0;
    check("late_swallow", 64'(m_ack_a), 64'h0);
    hold_a = 1'b0;
    @(negedge clk);
    check("late_swallow2", 64'(m_ack_a), 64'h0);
    acc_a(1, 30'h50, 1'b0, 32'h0, 4'hF, rd, err, lat, glat, cwd, cbs);
    check("post_to_data", 64'(rd), 64'h5A5A_0050);
    check("post_to_err",  64'(err), 64'h0);

    // Control register.
    m_addr_a[29:0] = 30'h0004_0000;
    #1 check("ctrl_cs", 64'(ctrl_cs_a), 64'h1);
    acc_a(0, 30'h0004_0000, 1'b0, 32'h0, 4'hF, rd, err, lat, glat, cwd, cbs);
    check("ctrl_rd1", 64'(rd), 64'h3);
    check("ctrl_lat", 64'(lat), 64'd1);
    acc_a(0, 30'h0004_0000, 1'b1, 32'h0, 4'hF, rd, err, lat, glat, cwd, cbs);
    acc_a(0, 30'h0004_0000, 1'b0, 32'h0, 4'hF, rd, err, lat, glat, cwd, cbs);
    check("ctrl_rd2", 64'(rd), 64'h1);

    // Reset while busy.
    hold_a = 1'b1;
    m_addr_a[59:30] = 30'h60; m_bytesel_a[7:4] = 4'hF; m_access_a[1] = 1'b1;
    seen = 0;
    for (int n = 0; n < 10 && seen == 0; n++) begin
      @(negedge clk);
      if (c_cs_a) seen = 1;
    end
    check("busy_before_rst", 64'(seen), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy_ccs", 64'(c_cs_a), 64'h0);
    check("rst_busy_ack", 64'({m_ack_a, m_error_a}), 64'h0);
    rst = 1'b0; m_access_a[1] = 1'b0; hold_a = 1'b0;
    @(negedge clk);
    check("rst_busy_noack", 64'({m_ack_a, m_error_a}), 64'h0);
    acc_a(1, 30'h60, 1'b0, 32'h0, 4'hF, rd, err, lat, glat, cwd, cbs);
    check("post_rst_data", 64'(rd), 64'h5A5A_0060);
    check("post_rst_err",  64'(err), 64'h0);

    check("single_ack", 64'(multi_ack), 64'h0);
    check("idle_outputs_zero", 64'(data_leak), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
